usart_tx_arbiter: RTL and testbench

//  Shares one USART_Tx instance between NUM_REQ byte-stream requesters, using round-robin arbitration.

---
 rtl/usart_tx_arbiter_pkg.sv | 5 +
 rtl/usart_rr_picker.sv | 22 ++
 rtl/usart_tx_arbiter.sv | 72 +++++++
 tb/tb_usart_tx_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/usart_tx_arbiter_pkg.sv
// usart_tx_arbiter_pkg: state encoding and shared defaults for the USART_Tx arbiter
package usart_tx_arbiter_pkg;
    localparam int DATA_BIT_DEF = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, LOCK = 2'd3} state_t;
endpackage

// File: rtl/usart_rr_picker.sv
// usart_rr_picker: first valid requester at or after the pointer, wrapping to 0
module usart_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int GW = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [GW-1:0]      ptr,
    output logic [GW-1:0]      winner,
    output logic               any_valid
);
    logic [GW-1:0] idx;
    always_comb begin
        winner = ptr;
        idx = '0;
        any_valid = |req_valid;
        // Walk offsets downward so the smallest offset from the pointer wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = GW'((int'(ptr) + i) % NUM_REQ);
            if (req_valid[idx]) winner = idx;
        end
    end
endmodule

// File: rtl/usart_tx_arbiter.sv
// usart_tx_arbiter: round-robin sharing of one USART_Tx among byte-stream requesters,
// holding the grant for a whole packet and aborting stalls with a watchdog.
module usart_tx_arbiter import usart_tx_arbiter_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int DATA_BIT = DATA_BIT_DEF,
    parameter int TIMEOUT_CYCLES = 200000,
    localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BIT-1:0]  req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_BIT-1:0]          tx_data,
    output logic                         tx_enable,
    input  logic                         tx_response,
    output logic [GW-1:0]                grant_id,
    output logic                         busy,
    output logic                         timeout_err
);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    state_t state, state_nx;
    logic [GW-1:0] ptr, winner, sel;
    logic [WW-1:0] wdog;
    logic last_q, any_valid, accept, expired;

    usart_rr_picker #(.NUM_REQ(NUM_REQ), .GW(GW)) u_picker (
        .req_valid(req_valid),
        .ptr(ptr),
        .winner(winner),
        .any_valid(any_valid)
    );

    always_comb begin
        sel = state == LOCK ? grant_id : winner;
        // Ready is forced low while reset is held so no requester sees a spurious accept.
        req_ready = reset && (state == LOCK || (state == IDLE && any_valid)) ? NUM_REQ'(1) << sel : '0;
        accept = |(req_valid & req_ready);
        expired = wdog == WW'(TIMEOUT_CYCLES - 1);
        timeout_err = expired && ((state == WAIT && !tx_response) || (state == LOCK && !accept));
        tx_enable = state == START;
        busy = state != IDLE;
        state_nx = state;
        case (state)
            IDLE:  state_nx = accept ? START : IDLE;
            START: state_nx = WAIT;
            WAIT:  state_nx = tx_response ? (last_q ? IDLE : LOCK) : (expired ? IDLE : WAIT);
            LOCK:  state_nx = accept ? START : (expired ? IDLE : LOCK);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr <= '0;
            wdog <= '0;
            last_q <= 1'b0;
            grant_id <= '0;
            tx_data <= '0;
        end else begin
            state <= state_nx;
            wdog <= ((state == WAIT && !tx_response) || state == LOCK) ? wdog + 1'b1 : '0;
            if (accept) begin
                tx_data <= DATA_BIT'(req_data >> (DATA_BIT * int'(sel)));
                last_q <= req_last[sel];
                grant_id <= sel;
            end
            if (state_nx == IDLE && busy) ptr <= grant_id == GW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        end
    end
endmodule

// File: tb/tb_usart_tx_arbiter.sv
// tb_usart_tx_arbiter: table-driven round-robin vectors plus directed lock, timeout and reset sequences
module tb_usart_tx_arbiter;
    logic clk = 1'b0, reset = 1'b0;
    logic [3:0] req_valid = '0, req_last = '0, req_ready;
    logic [31:0] req_data = '0;
    logic [7:0] tx_data;
    logic tx_enable, tx_response = 1'b0, busy, timeout_err;
    logic [1:0] grant_id;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    usart_tx_arbiter #(.NUM_REQ(4), .DATA_BIT(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .tx_data(tx_data),
        .tx_enable(tx_enable),
        .tx_response(tx_response),
        .grant_id(grant_id),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic [3:0] valid;
        logic [1:0] grant;
        logic [7:0] data;
        int delay;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic respond(input int d);
        repeat (d) @(negedge clk);
        tx_response = 1'b1;
        @(negedge clk);
        tx_response = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'b0001, 2'd0, 8'h55, 10};
        vecs[1]  = '{4'b1111, 2'd1, 8'h66, 2};
        vecs[2]  = '{4'b1111, 2'd2, 8'h77, 1};
        vecs[3]  = '{4'b1111, 2'd3, 8'h88, 3};
        vecs[4]  = '{4'b1111, 2'd0, 8'h55, 1};
        vecs[5]  = '{4'b1111, 2'd1, 8'h66, 2};
        vecs[6]  = '{4'b0101, 2'd2, 8'h77, 1};
        vecs[7]  = '{4'b0101, 2'd0, 8'h55, 1};
        vecs[8]  = '{4'b1000, 2'd3, 8'h88, 2};
        vecs[9]  = '{4'b0110, 2'd1, 8'h66, 1};
        vecs[10] = '{4'b0001, 2'd0, 8'h55, 1};

        #1;
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_txen", 32'(tx_enable), 32'(1'b0));
        chk("rst_ready", 32'(req_ready), 32'(4'b0000));
        chk("rst_grant", 32'(grant_id), 32'(2'd0));
        chk("rst_txdata", 32'(tx_data), 32'(8'h00));
        chk("rst_tmo", 32'(timeout_err), 32'(1'b0));
        @(negedge clk);
        reset = 1'b1;
        req_data = {8'h88, 8'h77, 8'h66, 8'h55};
        req_last = 4'b1111;

        for (int i = 0; i < 11; i++) begin
            req_valid = vecs[i].valid;
            #1;
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << vecs[i].grant));
            @(negedge clk);
            #1;
            chk("rr_txen", 32'(tx_enable), 32'(1'b1));
            chk("rr_txdata", 32'(tx_data), 32'(vecs[i].data));
            chk("rr_grant", 32'(grant_id), 32'(vecs[i].grant));
            chk("rr_start_ready", 32'(req_ready), 32'(4'b0000));
            respond(vecs[i].delay);
            req_valid = '0;
            #1;
            chk("rr_idle_busy", 32'(busy), 32'(1'b0));
            chk("rr_idle_txen", 32'(tx_enable), 32'(1'b0));
        end

        tx_response = 1'b1;
        @(negedge clk);
        tx_response = 1'b0;
        #1;
        chk("idle_resp_ignored", 32'(busy), 32'(1'b0));

        req_data[15:8] = 8'h11;
        req_last = 4'b1101;
        req_valid = 4'b0110;
        #1;
        chk("lock_first_ready", 32'(req_ready), 32'(4'b0010));
        @(negedge clk);
        #1;
        chk("lock_b1_data", 32'(tx_data), 32'(8'h11));
        respond(2);
        #1;
        chk("lock_b2_ready", 32'(req_ready), 32'(4'b0010));
        chk("lock_b2_busy", 32'(busy), 32'(1'b1));
        req_data[15:8] = 8'h12;
        @(negedge clk);
        #1;
        chk("lock_b2_data", 32'(tx_data), 32'(8'h12));
        chk("lock_b2_txen", 32'(tx_enable), 32'(1'b1));
        respond(2);
        req_data[15:8] = 8'h13;
        req_last[1] = 1'b1;
        #1;
        chk("lock_b3_ready", 32'(req_ready), 32'(4'b0010));
        @(negedge clk);
        #1;
        chk("lock_b3_data", 32'(tx_data), 32'(8'h13));
        @(negedge clk);
        #1;
        chk("lock_wait_ready", 32'(req_ready), 32'(4'b0000));
        respond(1);
        req_valid = 4'b0100;
        #1;
        chk("lock_next_ready", 32'(req_ready), 32'(4'b0100));
        @(negedge clk);
        #1;
        chk("lock_next_grant", 32'(grant_id), 32'(2'd2));
        chk("lock_next_data", 32'(tx_data), 32'(8'h77));
        req_valid = '0;
        respond(1);
        #1;
        chk("lock_done_busy", 32'(busy), 32'(1'b0));

        req_valid = 4'b1000;
        #1;
        chk("tmo_ready", 32'(req_ready), 32'(4'b1000));
        @(negedge clk);
        req_valid = '0;
        repeat (15) @(negedge clk);
        #1;
        chk("tmo_early", 32'(timeout_err), 32'(1'b0));
        @(negedge clk);
        #1;
        chk("tmo_pulse", 32'(timeout_err), 32'(1'b1));
        chk("tmo_busy", 32'(busy), 32'(1'b1));
        @(negedge clk);
        #1;
        chk("tmo_after", 32'(timeout_err), 32'(1'b0));
        chk("tmo_idle", 32'(busy), 32'(1'b0));

        req_valid = 4'b0001;
        #1;
        chk("tie_ready", 32'(req_ready), 32'(4'b0001));
        @(negedge clk);
        req_valid = '0;
        repeat (16) @(negedge clk);
        tx_response = 1'b1;
        #1;
        chk("tie_no_err", 32'(timeout_err), 32'(1'b0));
        @(negedge clk);
        tx_response = 1'b0;
        #1;
        chk("tie_idle", 32'(busy), 32'(1'b0));
        chk("tie_after", 32'(timeout_err), 32'(1'b0));

        req_data[7:0] = 8'h21;
        req_last = 4'b1110;
        req_valid = 4'b0001;
        #1;
        chk("stall_ready", 32'(req_ready), 32'(4'b0001));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("stall_data", 32'(tx_data), 32'(8'h21));
        respond(2);
        #1;
        chk("stall_lock_ready", 32'(req_ready), 32'(4'b0001));
        chk("stall_lock_busy", 32'(busy), 32'(1'b1));
        repeat (14) @(negedge clk);
        #1;
        chk("stall_early", 32'(timeout_err), 32'(1'b0));
        @(negedge clk);
        #1;
        chk("stall_pulse", 32'(timeout_err), 32'(1'b1));
        req_valid = 4'b1000;
        @(negedge clk);
        #1;
        chk("stall_after", 32'(timeout_err), 32'(1'b0));
        chk("stall_idle", 32'(busy), 32'(1'b0));
        chk("stall_next_ready", 32'(req_ready), 32'(4'b1000));
        @(negedge clk);
        #1;
        chk("stall_next_grant", 32'(grant_id), 32'(2'd3));
        chk("stall_next_txen", 32'(tx_enable), 32'(1'b1));

        req_valid = 4'b1111;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'(1'b0));
        chk("arst_txen", 32'(tx_enable), 32'(1'b0));
        chk("arst_ready", 32'(req_ready), 32'(4'b0000));
        chk("arst_grant", 32'(grant_id), 32'(2'd0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_first_ready", 32'(req_ready), 32'(4'b0001));
        @(negedge clk);
        #1;
        chk("arst_first_grant", 32'(grant_id), 32'(2'd0));
        chk("arst_first_txen", 32'(tx_enable), 32'(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
